// File: rtl/i2s_dac_tx_if.sv
// Stereo sample bundle from the synth plus the serial DAC pins and status flags.
// slave = transmitter side, master = synth / codec side.
interface i2s_dac_tx_if #(
  parameter int AUD_BIT_DEPTH = 24
);
  logic                     enable;
  logic [AUD_BIT_DEPTH-1:0] lsound_in;
  logic [AUD_BIT_DEPTH-1:0] rsound_in;
  logic                     sample_valid;
  logic                     sample_req;
  logic                     aud_bclk;
  logic                     aud_daclrck;
  logic                     aud_dacdat;
  logic                     underrun;
  logic                     overrun;

  modport slave (
    input  enable, lsound_in, rsound_in, sample_valid,
    output sample_req, aud_bclk, aud_daclrck, aud_dacdat, underrun, overrun
  );

  modport master (
    output enable, lsound_in, rsound_in, sample_valid,
    input  sample_req, aud_bclk, aud_daclrck, aud_dacdat, underrun, overrun
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified stereo DAC transmitter: derives BCLK/LRCK from AUDIO_CLK,
// double-buffers one stereo pair and paces the synth with a per-frame sample_req.
module i2s_dac_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4,
  parameter int I2S_MODE      = 1
) (
  input logic         AUDIO_CLK,
  input logic         reset_data,
  i2s_dac_tx_if.slave aud
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(BCLK_DIV);

  localparam logic [DW-1:0] DCNT_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DCNT_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] B_SLOT    = BW'(SLOT_BITS);
  localparam logic [BW-1:0] B_LOAD    = BW'(I2S_MODE);
  // When the right LSB spills into bit 0 of the next frame, draining stops one bit later.
  localparam logic [BW-1:0] B_END     = ((I2S_MODE != 0) && (SLOT_BITS == AUD_BIT_DEPTH)) ?
                                        BW'(1) : BW'(0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   dcnt_reg, dcnt_next;
  logic [BW-1:0]   b_reg, b_next, b_inc;
  logic            dcnt_wrap;
  logic            load;
  logic            running_next;
  logic            fresh_reg;
  logic            underrun_reg, overrun_reg;
  logic            bclk_reg, lrck_reg, dat_reg, req_reg;

  logic [AUD_BIT_DEPTH-1:0] shift_next [2];

  // Serial bit for frame position b, given the shift contents valid at that position.
  function automatic logic wire_bit(input logic [BW-1:0]            b,
                                    input logic [AUD_BIT_DEPTH-1:0] l,
                                    input logic [AUD_BIT_DEPTH-1:0] r);
    int                       p;
    logic [AUD_BIT_DEPTH-1:0] w;
    p = int'(b) - I2S_MODE;
    if (p < 0) p = p + FRAME_BITS;
    w = (p >= SLOT_BITS) ? r : l;
    if (p >= SLOT_BITS) p = p - SLOT_BITS;
    if (p >= AUD_BIT_DEPTH) return 1'b0;
    w = w << p;
    return w[AUD_BIT_DEPTH-1];
  endfunction

  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    b_next     = b_reg;
    load       = 1'b0;
    dcnt_wrap  = (dcnt_reg == DCNT_LAST);
    b_inc      = (b_reg == B_LAST) ? '0 : b_reg + 1'b1;
    unique case (state_reg)
      IDLE: begin
        if (aud.enable) begin
          state_next = RUN;
          dcnt_next  = '0;
          b_next     = '0;
          // Left-justified frames start with the left MSB at b=0, so entry is a load.
          load       = (I2S_MODE == 0);
        end
      end
      default: begin
        dcnt_next = dcnt_wrap ? '0 : dcnt_reg + 1'b1;
        if (dcnt_wrap) b_next = b_inc;
        if (state_reg == DRAIN && !aud.enable && dcnt_wrap && b_inc == B_END) begin
          state_next = IDLE;
          dcnt_next  = '0;
          b_next     = '0;
        end else begin
          state_next = aud.enable ? RUN : DRAIN;
          load       = dcnt_wrap && (b_inc == B_LOAD);
        end
      end
    endcase
  end

  assign running_next = (state_next != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [AUD_BIT_DEPTH-1:0] sample_in, hold_reg, shift_reg;

      assign sample_in = (gi == 0) ? aud.lsound_in : aud.rsound_in;
      // A pair arriving on the load edge bypasses the hold buffer.
      assign shift_next[gi] = !load ? shift_reg :
                              (aud.sample_valid ? sample_in : hold_reg);

      always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
          hold_reg  <= '0;
          shift_reg <= '0;
        end else begin
          if (aud.sample_valid) hold_reg <= sample_in;
          shift_reg <= shift_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      fresh_reg    <= 1'b0;
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (load) begin
      fresh_reg <= 1'b0;
      if (!fresh_reg && !aud.sample_valid) underrun_reg <= 1'b1;
    end else if (aud.sample_valid) begin
      fresh_reg <= 1'b1;
      if (fresh_reg) overrun_reg <= 1'b1;
    end
  end

  // Pin registers follow the next-state counters so BCLK, LRCK and data stay phase aligned.
  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      bclk_reg <= 1'b0;
      lrck_reg <= 1'b0;
      dat_reg  <= 1'b0;
      req_reg  <= 1'b0;
    end else begin
      bclk_reg <= running_next && (dcnt_next >= DCNT_HALF);
      lrck_reg <= running_next && (b_next >= B_SLOT);
      dat_reg  <= running_next && wire_bit(b_next, shift_next[0], shift_next[1]);
      req_reg  <= load;
    end
  end

  assign aud.aud_bclk    = bclk_reg;
  assign aud.aud_daclrck = lrck_reg;
  assign aud.aud_dacdat  = dat_reg;
  assign aud.sample_req  = req_reg;
  assign aud.underrun    = underrun_reg;
  assign aud.overrun     = overrun_reg;

endmodule
